alu_sequencer: RTL and testbench



---
 rtl/alu_sequencer_if.sv | 25 ++
 rtl/alu_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Instruction-in and result-out handshake bundle for the ALU sequencer.
// The master side offers instructions and accepts results; the slave side is the sequencer.
interface alu_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_opcode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_opcode;
  logic [WIDTH-1:0] out_result;

  modport master (
    output in_valid, in_opcode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_opcode, out_result
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, out_ready,
    output in_ready, out_valid, out_opcode, out_result
  );
endinterface

// File: rtl/alu_sequencer.sv
// Buffers {opcode, A, B} instructions, presents them to the decoder/ALU pair,
// waits a fixed settle interval, then hands the captured result downstream.
module alu_sequencer #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  parameter  int SETTLE = 2,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_sequencer_if.slave   bus,
  output logic [3:0]       opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [CW-1:0]    count,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] CNT_FULL    = CW'(DEPTH);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE - 1);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    HOLD = 2'b10
  } state_e;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } instr_t;

  instr_t           mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  state_e           state_q;
  logic [SW-1:0]    settle_q;
  logic [3:0]       opcode_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic             out_valid_q;
  logic [3:0]       out_opcode_q;
  logic [WIDTH-1:0] out_result_q;
  logic             busy_q;
  logic             push_s;
  logic             pop_s;
  logic             empty_s;
  instr_t           head_s;

  // Occupancy is registered, so a full FIFO refuses even when a pop happens this edge.
  assign bus.in_ready = (count_q < CNT_FULL);
  assign empty_s      = (count_q == '0);
  assign push_s       = bus.in_valid && bus.in_ready;
  assign head_s       = mem_q[rd_ptr_q];

  // Pop decision: fetch from IDLE, or on result acceptance in HOLD.
  always_comb begin
    pop_s = 1'b0;
    case (state_q)
      IDLE:    pop_s = !empty_s;
      HOLD:    pop_s = out_valid_q && bus.out_ready && !empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Next occupancy from push/pop pair.
  always_comb begin
    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Instruction storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= '{op: bus.in_opcode, a: bus.in_a, b: bus.in_b};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // Issue/settle/hold sequencer; 4'b0111 is the decoder no-op opcode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_q     <= '0;
      opcode_q     <= 4'b0111;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      out_valid_q  <= 1'b0;
      out_opcode_q <= 4'b0000;
      out_result_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop_s) begin
            opcode_q <= head_s.op;
            alu_a_q  <= head_s.a;
            alu_b_q  <= head_s.b;
            settle_q <= SETTLE_INIT;
            busy_q   <= 1'b1;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (settle_q == '0) begin
            out_result_q <= alu_result;
            out_opcode_q <= opcode_q;
            out_valid_q  <= 1'b1;
            state_q      <= HOLD;
          end else begin
            settle_q <= settle_q - SETTLE_ONE;
          end
        end
        HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (pop_s) begin
              opcode_q <= head_s.op;
              alu_a_q  <= head_s.a;
              alu_b_q  <= head_s.b;
              settle_q <= SETTLE_INIT;
              state_q  <= WAIT;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign opcode         = opcode_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_opcode = out_opcode_q;
  assign bus.out_result = out_result_q;
  assign count          = count_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus randomized bench for alu_sequencer with an ALU model that has
// one cycle of control latency and a queue-based scoreboard of expected results.
module tb_alu_sequencer;
  localparam int WIDTH = 8;

  typedef struct {
    logic [3:0] op;
    logic [7:0] res;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] opcode;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] count;
  logic       busy;
  logic [3:0] op_q = 4'b0111;
  logic [7:0] noise = 8'h00;
  logic       noise_en = 1'b0;
  logic       rand_rdy = 1'b0;
  logic       hold_seen = 1'b0;
  logic [3:0] held_op = 4'b0000;
  logic [7:0] held_res = 8'h00;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  exp_t       exp_q[$];
  int         acc_cyc[$];

  alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_sequencer #(.WIDTH(WIDTH), .DEPTH(4), .SETTLE(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .opcode     (opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .count      (count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      4'd6:    return {a[6:0], 1'b0};
      4'd7:    return a;
      default: return a + b + {4'b0000, op};
    endcase
  endfunction

  // ALU model: decoder registers the opcode, ALU computes combinationally.
  always @(posedge clk) begin
    op_q  <= opcode;
    noise <= 8'($urandom);
    cyc   <= cyc + 1;
  end
  assign alu_result = noise_en ? noise : alu_fn(op_q, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result scoreboard and hold-stability monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_seen <= 1'b0;
    end else begin
      if (hold_seen) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_opcode", 32'(bus.out_opcode), 32'(held_op));
        chk("hold_result", 32'(bus.out_result), 32'(held_res));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          chk("out_opcode", 32'(bus.out_opcode), 32'(exp_q[0].op));
          chk("out_result", 32'(bus.out_result), 32'(exp_q[0].res));
          void'(exp_q.pop_front());
        end
        acc_cyc.push_back(cyc);
      end
      hold_seen <= bus.out_valid && !bus.out_ready;
      held_op   <= bus.out_opcode;
      held_res  <= bus.out_result;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = 1'($urandom);
  endtask

  task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int w = 0;
    bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_a = a; bus.in_b = b;
    while (!bus.in_ready && w < 60) begin tick(); w++; end
    chk("push_timeout", 32'(w < 60), 32'd1);
    if (w < 60) begin
      exp_q.push_back('{op: op, res: alu_fn(op, a, b)});
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int w = 0;
    while (!bus.out_valid && w < 20) begin tick(); w++; end
    chk("valid_timeout", 32'(w < 20), 32'd1);
  endtask

  task automatic drain();
    int w = 0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.out_valid) && w < 300) begin tick(); w++; end
    chk("drain_timeout", 32'(w < 300), 32'd1);
  endtask

  initial begin
    logic [7:0] ra, rb, held;
    logic [3:0] bop;
    logic [7:0] ba, bb;
    int base;
    bus.in_valid = 1'b0; bus.in_opcode = 4'h0; bus.in_a = 8'h00; bus.in_b = 8'h00;
    bus.out_ready = 1'b0;

    // Reset values
    #12;
    chk("rst_opcode", 32'(opcode), 32'h7);
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    chk("rst_alu_b", 32'(alu_b), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_result", 32'(bus.out_result), 32'h0);
    chk("rst_out_opcode", 32'(bus.out_opcode), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    rst_n = 1'b1;
    tick();

    // Single op latency: push at edge T, result valid after T+3
    push(4'b0010, 8'h05, 8'h03);
    chk("lat_t0_count", 32'(count), 32'd1);
    chk("lat_t0_opcode", 32'(opcode), 32'h7);
    tick();
    chk("lat_t1_opcode", 32'(opcode), 32'h2);
    chk("lat_t1_alu_a", 32'(alu_a), 32'h05);
    chk("lat_t1_alu_b", 32'(alu_b), 32'h03);
    chk("lat_t1_busy", 32'(busy), 32'd1);
    chk("lat_t1_count", 32'(count), 32'd0);
    tick();
    chk("lat_t2_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("lat_t3_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_t3_result", 32'(bus.out_result), 32'h08);
    chk("lat_t3_opcode", 32'(bus.out_opcode), 32'h2);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("lat_after_valid", 32'(bus.out_valid), 32'd0);
    chk("lat_after_busy", 32'(busy), 32'd0);
    chk("lat_queue_empty", 32'(exp_q.size()), 32'd0);

    // Fill/full with out_ready low
    for (int i = 0; i < 5; i++) push(4'($urandom), 8'($urandom), 8'($urandom));
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    ra = 8'($urandom); rb = 8'($urandom);
    bus.in_valid = 1'b1; bus.in_opcode = 4'b0100; bus.in_a = ra; bus.in_b = rb;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_stall_count", 32'(count), 32'd4);
      chk("full_stall_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("full_pop_count", 32'(count), 32'd3);
    chk("full_pop_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back('{op: 4'b0100, res: alu_fn(4'b0100, ra, rb)});
    tick();
    bus.in_valid = 1'b0;
    chk("full_refill_count", 32'(count), 32'd4);
    drain();
    bus.out_ready = 1'b0;

    // Backpressure with a changing ALU output
    push(4'b0011, 8'h40, 8'h11);
    bop = 4'($urandom); ba = 8'($urandom); bb = 8'($urandom);
    push(bop, ba, bb);
    wait_valid();
    held = bus.out_result;
    chk("bp_captured", 32'(held), 32'h2F);
    noise_en = 1'b1;
    repeat (10) tick();
    noise_en = 1'b0;
    chk("bp_stable_result", 32'(bus.out_result), 32'h2F);
    chk("bp_stable_opcode", 32'(bus.out_opcode), 32'h3);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bp_issue_opcode", 32'(opcode), 32'(bop));
    chk("bp_issue_a", 32'(alu_a), 32'(ba));
    chk("bp_issue_b", 32'(alu_b), 32'(bb));
    chk("bp_issue_busy", 32'(busy), 32'd1);
    drain();

    // Back-to-back results with out_ready high
    base = acc_cyc.size();
    bus.out_ready = 1'b1;
    push(4'b0110, 8'($urandom), 8'($urandom));
    push(4'b0111, 8'($urandom), 8'($urandom));
    push(4'b0011, 8'($urandom), 8'($urandom));
    drain();
    chk("b2b_count", 32'(acc_cyc.size() - base), 32'd3);
    if (acc_cyc.size() - base == 3) begin
      chk("b2b_gap1", 32'(acc_cyc[base + 1] - acc_cyc[base]), 32'd3);
      chk("b2b_gap2", 32'(acc_cyc[base + 2] - acc_cyc[base + 1]), 32'd3);
    end

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) push(4'($urandom), 8'($urandom), 8'($urandom));
    rand_rdy = 1'b0;
    drain();
    bus.out_ready = 1'b0;

    // Reset mid-WAIT with two entries queued
    push(4'b0001, 8'($urandom), 8'($urandom));
    push(4'b0010, 8'($urandom), 8'($urandom));
    push(4'b0100, 8'($urandom), 8'($urandom));
    chk("mid_count", 32'(count), 32'd2);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_valid", 32'(bus.out_valid), 32'd0);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_opcode", 32'(opcode), 32'h7);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    #14 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    end
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_opcode", 32'(opcode), 32'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
